// File: rtl/bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge read path: default AXI IDs,
// SRAM-side size encodings, arbiter FSM states and the requester enumeration.
package bridge_pkg;

  localparam int unsigned      ID_W        = 4;
  localparam logic [ID_W-1:0]  INST_ID_DEF = 4'd0;
  localparam logic [ID_W-1:0]  DATA_ID_DEF = 4'd1;

  // SRAM-side transfer size encodings
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Only one AR may be in flight on the bus at a time
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_AR_BUSY = 1'b1
  } ar_state_e;

  // Requester identity, used for the round-robin history
  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_e;

  // Map the SRAM size code onto the AXI arsize field (bytes = 2**arsize)
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    logic [2:0] res;
    case (size)
      SIZE_B:  res = 3'd0;
      SIZE_H:  res = 3'd1;
      SIZE_W:  res = 3'd2;
      default: res = {1'b0, size};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rd_outstanding_cnt.sv
// Outstanding-read counter for one AXI ID. Counts accepted-but-unreturned
// reads, flags when the limit is reached and saturates at both ends so a
// stray return (protocol error) can never wrap the count.
module rd_outstanding_cnt #(
  parameter int unsigned MAX   = 4,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: simultaneous inc and dec cancel; saturate at 0 and at MAX
  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q < MAX_CNT) count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) count_q <= '0;
    else         count_q <= count_d;
  end

  assign full  = (count_q >= MAX_CNT);
  assign count = count_q;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: shares one AXI AR/R channel between the inst and data
// SRAM-like read ports. Grants round-robin from IDLE, holds the AR beat until
// accepted, tracks outstanding reads per ID and steers R beats back by rid.
module axi_rd_arbiter
  import bridge_pkg::*;
#(
  parameter int unsigned     MAX_OUTSTANDING = 4,
  parameter logic [ID_W-1:0] INST_ID         = INST_ID_DEF,
  parameter logic [ID_W-1:0] DATA_ID         = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  // inst read port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data read port
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic        data_rd_hold,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  ar_state_e       state_q, state_d;
  port_e           last_grant_q, last_grant_d;
  logic [ID_W-1:0] arid_q, arid_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [2:0]      arsize_q, arsize_d;

  logic             inst_elig, data_elig;
  logic             grant_inst, grant_data, grant_any;
  logic             inst_ret, data_ret;
  logic             inst_full, data_full;
  logic [CNT_W-1:0] inst_cnt, data_cnt;

  // A return is a completed single-beat read; unknown IDs are dropped
  assign inst_ret = rvalid && rlast && (rid == INST_ID);
  assign data_ret = rvalid && rlast && (rid == DATA_ID);

  // A full counter or a pending write-side hazard blocks new grants only
  assign inst_elig = inst_req && !inst_full;
  assign data_elig = data_req && !data_rd_hold && !data_full;

  // Round-robin pick among eligible requesters; only an idle channel grants
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn && (state_q == ST_IDLE)) begin
      if (inst_elig && data_elig) begin
        grant_inst = (last_grant_q == PORT_DATA);
        grant_data = (last_grant_q == PORT_INST);
      end else begin
        grant_inst = inst_elig;
        grant_data = data_elig;
      end
    end
  end

  assign grant_any = grant_inst || grant_data;

  // FSM state, round-robin history and AR payload registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_DATA;
      arid_q       <= '0;
      araddr_q     <= '0;
      arsize_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arsize_q     <= arsize_d;
    end
  end

  // Next state: leave IDLE on a grant, come back once the slave takes the AR
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_any) state_d = ST_AR_BUSY;
      ST_AR_BUSY: if (arready)   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs: addr_ok pulses in the grant cycle, AR payload is captured then
  // and stays frozen through AR_BUSY until arready
  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    arvalid      = (state_q == ST_AR_BUSY);
    last_grant_d = last_grant_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arsize_d     = arsize_q;
    if (grant_inst) begin
      last_grant_d = PORT_INST;
      arid_d       = INST_ID;
      araddr_d     = inst_addr;
      arsize_d     = axi_size(inst_size);
    end else if (grant_data) begin
      last_grant_d = PORT_DATA;
      arid_d       = DATA_ID;
      araddr_d     = data_addr;
      arsize_d     = axi_size(data_size);
    end
  end

  assign arid   = arid_q;
  assign araddr = araddr_q;
  assign arsize = arsize_q;

  // Both requesters always accept read data, so R is never back-pressured
  assign rready       = 1'b1;
  assign inst_data_ok = resetn && inst_ret;
  assign data_data_ok = resetn && data_ret;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  rd_outstanding_cnt #(
    .MAX   (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_inst_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (grant_inst),
    .dec    (inst_ret),
    .full   (inst_full),
    .count  (inst_cnt)
  );

  rd_outstanding_cnt #(
    .MAX   (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_data_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (grant_data),
    .dec    (data_ret),
    .full   (data_full),
    .count  (data_cnt)
  );

  // The grant logic must never push a requester past its outstanding limit
  a_inst_cnt_max: assert property (@(posedge clk) disable iff (!resetn) inst_cnt <= MAX_CNT);
  a_data_cnt_max: assert property (@(posedge clk) disable iff (!resetn) data_cnt <= MAX_CNT);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Testbench for axi_rd_arbiter: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a transaction-level reference model.
module tb_axi_rd_arbiter;
  import bridge_pkg::*;

  localparam int         MAX = 4;
  localparam logic [3:0] IID = 4'd0;
  localparam logic [3:0] DID = 4'd1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic [1:0]  inst_size;
  logic        data_req, data_rd_hold, data_addr_ok, data_data_ok;
  logic [31:0] data_addr, data_rdata;
  logic [1:0]  data_size;
  logic [3:0]  arid, rid;
  logic [31:0] araddr, rdata;
  logic [2:0]  arsize;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.MAX_OUTSTANDING(MAX), .INST_ID(IID), .DATA_ID(DID)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_rd_hold(data_rd_hold), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: outstanding reads per requester as address queues,
  // plus the single AR slot on the bus
  logic [31:0] mq_i[$], mq_d[$];
  bit          m_busy, m_last_data;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  // Slave side: reads the slave has accepted on AR and still owes on R
  logic [31:0] sq_i[$], sq_d[$];

  bit inst_repeat, data_repeat, post_gi, post_gd;
  int ar_mode, r_mode, force_ret;
  int n_gi, n_gd, n_ri, n_rd, n_arv;
  bit grant_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hc3a5_5a3c;
  endfunction

  task automatic clear_stats();
    n_gi = 0; n_gd = 0; n_ri = 0; n_rd = 0; n_arv = 0;
    grant_log.delete();
  endtask

  task automatic model_clear();
    mq_i.delete(); mq_d.delete(); sq_i.delete(); sq_d.delete();
    m_busy = 1'b0; m_last_data = 1'b1;
    m_arid = '0; m_araddr = '0; m_arsize = '0;
    post_gi = 1'b0; post_gd = 1'b0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  task automatic model_step();
    bit ie, de, gi, gd, ri, rd;
    logic [31:0] exp_rd;
    ie = inst_req && (mq_i.size() < MAX);
    de = data_req && !data_rd_hold && (mq_d.size() < MAX);
    gi = 1'b0; gd = 1'b0;
    if (!m_busy) begin
      if (ie && de) begin gi = m_last_data; gd = !m_last_data; end
      else begin gi = ie; gd = de; end
    end
    ri = rvalid && rlast && (rid == IID);
    rd = rvalid && rlast && (rid == DID);
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(gi));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(gd));
    chk("arvalid", 32'(arvalid), 32'(m_busy));
    chk("arid", 32'(arid), 32'(m_arid));
    chk("araddr", araddr, m_araddr);
    chk("arsize", 32'(arsize), 32'(m_arsize));
    chk("rready", 32'(rready), 32'd1);
    chk("inst_data_ok", 32'(inst_data_ok), 32'(ri));
    chk("data_data_ok", 32'(data_data_ok), 32'(rd));
    if (ri) begin
      exp_rd = (mq_i.size() > 0) ? memf(mq_i.pop_front()) : rdata;
      chk("inst_rdata", inst_rdata, exp_rd);
      n_ri++;
    end
    if (rd) begin
      exp_rd = (mq_d.size() > 0) ? memf(mq_d.pop_front()) : rdata;
      chk("data_rdata", data_rdata, exp_rd);
      n_rd++;
    end
    if (arvalid) n_arv++;
    if (gi) begin n_gi++; grant_log.push_back(1'b0); end
    if (gd) begin n_gd++; grant_log.push_back(1'b1); end
    if (m_busy && arready) begin
      if (m_arid == IID) sq_i.push_back(m_araddr);
      else               sq_d.push_back(m_araddr);
      m_busy = 1'b0;
    end
    if (gi) begin
      m_busy = 1'b1; m_last_data = 1'b0;
      m_arid = IID; m_araddr = inst_addr; m_arsize = {1'b0, inst_size};
      mq_i.push_back(inst_addr);
    end
    if (gd) begin
      m_busy = 1'b1; m_last_data = 1'b1;
      m_arid = DID; m_araddr = data_addr; m_arsize = {1'b0, data_size};
      mq_d.push_back(data_addr);
    end
    post_gi = gi; post_gd = gd;
  endtask

  // AXI slave stimulus for the coming cycle
  task automatic drive_slave();
    int pick;
    rvalid = 1'b0; rid = '0; rdata = '0; rlast = 1'b1;
    case (ar_mode)
      0:       arready = 1'($urandom_range(0, 1));
      1:       arready = 1'b1;
      default: arready = 1'b0;
    endcase
    pick = -1;
    if (force_ret >= 0) begin
      pick = force_ret; force_ret = -1;
    end else if (r_mode == 0 && $urandom_range(0, 2) == 0) begin
      if ($urandom_range(0, 9) == 0)              pick = 5;
      else if (sq_i.size() > 0 && sq_d.size() > 0) pick = ($urandom_range(0, 1) == 1) ? int'(DID) : int'(IID);
      else if (sq_i.size() > 0)                    pick = int'(IID);
      else if (sq_d.size() > 0)                    pick = int'(DID);
    end else if (r_mode == 2) begin
      if (sq_i.size() > 0)      pick = int'(IID);
      else if (sq_d.size() > 0) pick = int'(DID);
    end
    if (pick >= 0) begin
      rvalid = 1'b1; rid = 4'(pick); rdata = $urandom;
      if (pick == int'(IID) && sq_i.size() > 0)      rdata = memf(sq_i.pop_front());
      else if (pick == int'(DID) && sq_d.size() > 0) rdata = memf(sq_d.pop_front());
    end
  endtask

  // One clock: drive after the edge, sample 1 unit before the next edge
  task automatic cycle();
    drive_slave();
    @(negedge clk); #4;
    model_step();
    @(posedge clk); #1;
    if (post_gi) begin
      if (inst_repeat) inst_addr = inst_addr + 32'h4;
      else             inst_req  = 1'b0;
    end
    if (post_gd) begin
      if (data_repeat) data_addr = data_addr + 32'h4;
      else             data_req  = 1'b0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = '0; inst_size = '0;
    data_req = 1'b0; data_addr = '0; data_size = '0; data_rd_hold = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rlast = 1'b1;
    inst_repeat = 1'b0; data_repeat = 1'b0;
    ar_mode = 0; r_mode = 0; force_ret = -1;
    model_clear();
    clear_stats();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic rand_inputs();
    if (!inst_req && $urandom_range(0, 2) == 0) begin
      inst_req = 1'b1; inst_addr = $urandom & 32'hffff_fffc; inst_size = 2'($urandom_range(0, 2));
    end
    if (!data_req && $urandom_range(0, 2) == 0) begin
      data_req = 1'b1; data_addr = $urandom; data_size = 2'($urandom_range(0, 2));
    end
    data_rd_hold = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    // Single inst read; arready one cycle after arvalid; one return
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1fc0_0000; inst_size = SIZE_W;
    ar_mode = 2; r_mode = 1;
    cycle();
    cycle();
    ar_mode = 1;
    cycle();
    ar_mode = 2; force_ret = int'(IID);
    cycle();
    chk("single_ret_count", 32'(n_ri), 32'd1);
    cycle();
    chk("single_grants", 32'(n_gi), 32'd1);

    // Both requesters held: grants alternate starting with inst
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_1000; inst_repeat = 1'b1;
    data_req = 1'b1; data_addr = 32'h8000_0000; data_repeat = 1'b1; data_size = SIZE_H;
    ar_mode = 1; r_mode = 2;
    repeat (18) cycle();
    chk("rr_grant_total", 32'(grant_log.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk($sformatf("rr_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // Data hold blocks grants; release grants in the same cycle
    do_reset();
    data_req = 1'b1; data_addr = 32'h0000_0400; data_size = SIZE_B; data_rd_hold = 1'b1;
    ar_mode = 1; r_mode = 1;
    repeat (10) cycle();
    chk("hold_no_grant", 32'(n_gd), 32'd0);
    chk("hold_no_arvalid", 32'(n_arv), 32'd0);
    data_rd_hold = 1'b0;
    cycle();
    chk("hold_release_grant", 32'(n_gd), 32'd1);

    // arready low for 5 cycles, then out-of-order returns data before inst
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h8000_0040; inst_size = SIZE_H;
    data_req = 1'b1; data_addr = 32'h0000_2220; data_size = SIZE_W;
    ar_mode = 2; r_mode = 1;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_araddr", araddr, 32'h8000_0040);
    end
    chk("stall_no_data_grant", 32'(n_gd), 32'd0);
    ar_mode = 1;
    repeat (3) cycle();
    chk("ooo_data_granted", 32'(n_gd), 32'd1);
    force_ret = int'(DID);
    cycle();
    force_ret = int'(IID);
    cycle();
    chk("ooo_inst_ret", 32'(n_ri), 32'd1);
    chk("ooo_data_ret", 32'(n_rd), 32'd1);

    // Reset asserted mid AR_BUSY
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_3000; inst_size = SIZE_W;
    ar_mode = 2; r_mode = 1;
    cycle();
    cycle();
    chk("pre_rst_arvalid", 32'(arvalid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    inst_req = 1'b1; data_req = 1'b1; rvalid = 1'b1; rlast = 1'b1; rid = 4'd5;
    #1;
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    rid = IID;
    #1;
    chk("rst_inst_data_ok_id0", 32'(inst_data_ok), 32'd0);
    do_reset();
    r_mode = 1; ar_mode = 1;
    force_ret = 5;
    cycle();
    chk("bogus_rid_ignored", 32'(n_ri + n_rd), 32'd0);
    // A return with nothing outstanding must not wrap the counter
    force_ret = int'(IID);
    cycle();

    // Counter limit: 4 grants, then none until one return
    clear_stats();
    inst_req = 1'b1; inst_addr = 32'h0000_2000; inst_size = SIZE_W; inst_repeat = 1'b1;
    repeat (16) cycle();
    chk("max_grants", 32'(n_gi), 32'd4);
    force_ret = int'(IID);
    cycle();
    chk("max_full_on_ret_cycle", 32'(n_gi), 32'd4);
    cycle();
    chk("max_regrant", 32'(n_gi), 32'd5);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      cycle();
    end
    chk("rand_activity", 32'((n_gi > 50) && (n_gd > 50)), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
